// File: rtl/traceback_ptr_ctrl_if.sv
// Handshake and key bus between the traceback control FSM (master)
// and the traceback pointer controller (slave).
interface traceback_ptr_ctrl_if #(
   parameter int word_num_bit = 4,
   parameter int POS_num_bit  = 4
);
   logic                    RW_Key_reg;
   logic [word_num_bit-1:0] key_Key_reg;
   logic                    start;
   logic [POS_num_bit-1:0]  len_i;
   logic                    dir;
   logic                    step_en;
   logic [word_num_bit-1:0] key_o;
   logic [POS_num_bit-1:0]  steps_left;
   logic                    busy;
   logic                    done;
   logic                    wrap_o;

   modport master (
      output RW_Key_reg, key_Key_reg, start, len_i, dir, step_en,
      input  key_o, steps_left, busy, done, wrap_o
   );

   modport slave (
      input  RW_Key_reg, key_Key_reg, start, len_i, dir, step_en,
      output key_o, steps_left, busy, done, wrap_o
   );
endinterface

// File: rtl/traceback_ptr_ctrl.sv
// Traceback pointer controller: holds the survivor-memory word index and walks
// it up or down (wrapping or saturating) for a programmed number of steps.
module traceback_ptr_ctrl #(
   parameter int word_num     = 16,
   parameter int word_num_bit = 4,
   parameter int POS_num      = 11,
   parameter int POS_num_bit  = 4,
   parameter bit WRAP_MODE    = 1'b1
) (
   input logic                clk,
   input logic                reset,
   traceback_ptr_ctrl_if.slave bus
);

   localparam logic [word_num_bit-1:0] KEY_MAX = word_num_bit'(word_num - 1);
   localparam logic [word_num_bit-1:0] KEY_MOD = word_num_bit'(word_num);
   localparam logic [POS_num_bit-1:0]  LEN_MAX = POS_num_bit'(POS_num);
   localparam logic [word_num_bit-1:0] KEY_ONE = word_num_bit'(1);
   localparam logic [POS_num_bit-1:0]  CNT_ONE = POS_num_bit'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state_q, state_d;
   logic [word_num_bit-1:0] key_q, key_d, load_val;
   logic [POS_num_bit-1:0]  steps_q, steps_d, len_clamped;
   logic                    wrap_q, wrap_d;
   logic                    done_q;

   // Keys at or above word_num fold back into range; one subtraction suffices
   // because the key width is ceil(log2(word_num)).
   assign load_val    = (bus.key_Key_reg > KEY_MAX) ? bus.key_Key_reg - KEY_MOD : bus.key_Key_reg;
   assign len_clamped = (bus.len_i > LEN_MAX) ? LEN_MAX : bus.len_i;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      steps_d = steps_q;
      wrap_d  = 1'b0;
      if (bus.RW_Key_reg) begin
         key_d   = load_val;
         steps_d = '0;
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (bus.start) begin
               if (len_clamped == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = RUN;
                  steps_d = len_clamped;
               end
            end
            RUN: if (bus.step_en) begin
               steps_d = steps_q - CNT_ONE;
               if (steps_q == CNT_ONE) state_d = DONE;
               if (!bus.dir) begin
                  if (key_q == '0) begin
                     wrap_d = 1'b1;
                     key_d  = WRAP_MODE ? KEY_MAX : '0;
                  end else begin
                     key_d = key_q - KEY_ONE;
                  end
               end else if (key_q == KEY_MAX) begin
                  wrap_d = 1'b1;
                  key_d  = WRAP_MODE ? '0 : KEY_MAX;
               end else begin
                  key_d = key_q + KEY_ONE;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         key_q   <= '0;
         steps_q <= '0;
         wrap_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         steps_q <= steps_d;
         wrap_q  <= wrap_d;
         done_q  <= (state_d == DONE);
      end
   end

   assign bus.key_o      = key_q;
   assign bus.steps_left = steps_q;
   assign bus.busy       = (state_q == RUN);
   assign bus.done       = done_q;
   assign bus.wrap_o     = wrap_q;

endmodule

// File: tb/tb_traceback_ptr_ctrl.sv
// Directed bench for traceback_ptr_ctrl: wrapping 16-word, saturating 16-word
// and wrapping 11-word instances driven from one linear stimulus sequence.
module tb_traceback_ptr_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   traceback_ptr_ctrl_if #(.word_num_bit(4), .POS_num_bit(4)) a0 ();
   traceback_ptr_ctrl_if #(.word_num_bit(4), .POS_num_bit(4)) a1 ();
   traceback_ptr_ctrl_if #(.word_num_bit(4), .POS_num_bit(4)) a2 ();

   traceback_ptr_ctrl #(.word_num(16), .word_num_bit(4), .POS_num(11), .POS_num_bit(4), .WRAP_MODE(1'b1))
      u_wrap16 (.clk(clk), .reset(reset), .bus(a0));
   traceback_ptr_ctrl #(.word_num(16), .word_num_bit(4), .POS_num(11), .POS_num_bit(4), .WRAP_MODE(1'b0))
      u_sat16 (.clk(clk), .reset(reset), .bus(a1));
   traceback_ptr_ctrl #(.word_num(11), .word_num_bit(4), .POS_num(11), .POS_num_bit(4), .WRAP_MODE(1'b1))
      u_wrap11 (.clk(clk), .reset(reset), .bus(a2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic quiet_all();
      a0.RW_Key_reg = 0; a0.key_Key_reg = '0; a0.start = 0; a0.len_i = '0; a0.dir = 0; a0.step_en = 0;
      a1.RW_Key_reg = 0; a1.key_Key_reg = '0; a1.start = 0; a1.len_i = '0; a1.dir = 0; a1.step_en = 0;
      a2.RW_Key_reg = 0; a2.key_Key_reg = '0; a2.start = 0; a2.len_i = '0; a2.dir = 0; a2.step_en = 0;
   endtask

   initial begin
      quiet_all();
      reset = 1'b0;
      #12;
      check("rst_key",   a0.key_o, 0);
      check("rst_steps", a0.steps_left, 0);
      check("rst_busy",  a0.busy, 0);
      check("rst_done",  a0.done, 0);
      check("rst_wrap",  a0.wrap_o, 0);
      reset = 1'b1;
      tick();

      // Wrapping decrement walk: 3 -> 2,1,0,15
      a0.RW_Key_reg = 1; a0.key_Key_reg = 4'd3;
      tick();
      a0.RW_Key_reg = 0;
      check("t2_load", a0.key_o, 3);
      a0.step_en = 1;
      tick();
      check("idle_step_key", a0.key_o, 3);
      check("idle_step_cnt", a0.steps_left, 0);
      a0.step_en = 0; a0.start = 1; a0.len_i = 4'd4; a0.dir = 0;
      tick();
      a0.start = 0;
      check("t2_busy",  a0.busy, 1);
      check("t2_steps", a0.steps_left, 4);
      a0.step_en = 1;
      tick(); check("t2_k1", a0.key_o, 2);  check("t2_s1", a0.steps_left, 3); check("t2_w1", a0.wrap_o, 0);
      tick(); check("t2_k2", a0.key_o, 1);  check("t2_d2", a0.done, 0);
      tick(); check("t2_k3", a0.key_o, 0);  check("t2_s3", a0.steps_left, 1); check("t2_w3", a0.wrap_o, 0);
      tick(); check("t2_k4", a0.key_o, 15); check("t2_w4", a0.wrap_o, 1);
      check("t2_done", a0.done, 1); check("t2_busy_end", a0.busy, 0); check("t2_s4", a0.steps_left, 0);
      a0.step_en = 0;
      tick(); check("t2_done_off", a0.done, 0); check("t2_wrap_off", a0.wrap_o, 0); check("t2_k5", a0.key_o, 15);

      // Zero length goes straight to DONE; oversize length clamps to POS_num
      a0.start = 1; a0.len_i = 4'd0;
      tick();
      a0.start = 0;
      check("t5_done0", a0.done, 1); check("t5_busy0", a0.busy, 0);
      tick(); check("t5_done0_off", a0.done, 0); check("t5_busy0b", a0.busy, 0);
      a0.start = 1; a0.len_i = 4'd15; a0.dir = 1;
      tick();
      a0.start = 0;
      check("t5_clamp", a0.steps_left, 11); check("t5_busy", a0.busy, 1);

      // Load and start together mid-run: load wins, run aborted without done
      a0.RW_Key_reg = 1; a0.start = 1; a0.key_Key_reg = 4'd5; a0.len_i = 4'd3;
      tick();
      a0.RW_Key_reg = 0; a0.start = 0;
      check("t6_key", a0.key_o, 5); check("t6_steps", a0.steps_left, 0);
      check("t6_busy", a0.busy, 0); check("t6_done", a0.done, 0);
      tick(); check("t6_done_later", a0.done, 0); check("t6_busy_later", a0.busy, 0);

      // Saturating decrement: 1 -> 0,0,0 with wrap on the last two steps
      a1.RW_Key_reg = 1; a1.key_Key_reg = 4'd1;
      tick();
      a1.RW_Key_reg = 0; a1.start = 1; a1.len_i = 4'd3; a1.dir = 0;
      tick();
      a1.start = 0; a1.step_en = 1;
      tick(); check("t3_k1", a1.key_o, 0); check("t3_w1", a1.wrap_o, 0);
      tick(); check("t3_k2", a1.key_o, 0); check("t3_w2", a1.wrap_o, 1); check("t3_d2", a1.done, 0);
      tick(); check("t3_k3", a1.key_o, 0); check("t3_w3", a1.wrap_o, 1); check("t3_d3", a1.done, 1);
      a1.step_en = 0;
      tick(); check("t3_d4", a1.done, 0);

      // Saturating increment at top of range
      a1.RW_Key_reg = 1; a1.key_Key_reg = 4'd15;
      tick();
      a1.RW_Key_reg = 0; a1.start = 1; a1.len_i = 4'd1; a1.dir = 1;
      tick();
      a1.start = 0; a1.step_en = 1;
      tick(); check("sat_up_key", a1.key_o, 15); check("sat_up_wrap", a1.wrap_o, 1); check("sat_up_done", a1.done, 1);
      a1.step_en = 0;

      // Non-power-of-two depth: 10 -> 0 (wrap) -> 1, and out-of-range load folds
      a2.RW_Key_reg = 1; a2.key_Key_reg = 4'd10;
      tick();
      a2.RW_Key_reg = 0; a2.start = 1; a2.len_i = 4'd2; a2.dir = 1;
      tick();
      a2.start = 0; a2.step_en = 1;
      tick(); check("t4_k1", a2.key_o, 0); check("t4_w1", a2.wrap_o, 1); check("t4_d1", a2.done, 0);
      tick(); check("t4_k2", a2.key_o, 1); check("t4_w2", a2.wrap_o, 0); check("t4_d2", a2.done, 1);
      a2.step_en = 0; a2.RW_Key_reg = 1; a2.key_Key_reg = 4'd13;
      tick();
      a2.RW_Key_reg = 0;
      check("t4_fold", a2.key_o, 2);
      a2.start = 1; a2.len_i = 4'd1; a2.dir = 0;
      tick();
      a2.start = 0; a2.step_en = 1;
      tick(); check("t4_k0", a2.key_o, 1);
      a2.step_en = 0;
      a2.RW_Key_reg = 1; a2.key_Key_reg = 4'd0;
      tick();
      a2.RW_Key_reg = 0; a2.start = 1; a2.len_i = 4'd1; a2.dir = 0;
      tick();
      a2.start = 0; a2.step_en = 1;
      tick(); check("t4_wrap_dn", a2.key_o, 10); check("t4_wrap_dn_w", a2.wrap_o, 1);
      a2.step_en = 0;

      // Asynchronous reset in the middle of a run with key 7
      a0.RW_Key_reg = 1; a0.key_Key_reg = 4'd7;
      tick();
      a0.RW_Key_reg = 0; a0.start = 1; a0.len_i = 4'd5; a0.dir = 1;
      tick();
      a0.start = 0;
      check("t1_busy_pre", a0.busy, 1); check("t1_key_pre", a0.key_o, 7);
      #2 reset = 1'b0;
      #1;
      check("t1_key",   a0.key_o, 0);
      check("t1_steps", a0.steps_left, 0);
      check("t1_busy",  a0.busy, 0);
      check("t1_done",  a0.done, 0);
      check("t1_wrap",  a0.wrap_o, 0);
      a0.step_en = 1;
      tick();
      check("t1_held_busy", a0.busy, 0); check("t1_held_key", a0.key_o, 0);
      reset = 1'b1;
      tick();
      check("t1_idle_busy", a0.busy, 0); check("t1_idle_key", a0.key_o, 0);
      a0.step_en = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
